// File: rtl/jk_bank_ctrl.sv
// Command-driven controller for a bank of JK flip-flops with masked set/reset/toggle and counting.
// Define JK_BANK_DOWN_COUNT_EN to enable the COUNT_DOWN opcode (101); otherwise it is rejected as illegal.
module jk_bank_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [CNT_W-1:0] cmd_len,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, APPLY, COUNT, DONE} state_t;

    localparam logic [2:0] OP_SET    = 3'b001;
    localparam logic [2:0] OP_RESET  = 3'b010;
    localparam logic [2:0] OP_TOGGLE = 3'b011;
    localparam logic [2:0] OP_UP     = 3'b100;
`ifdef JK_BANK_DOWN_COUNT_EN
    localparam logic [2:0] OP_DOWN   = 3'b101;
`endif

    state_t           state;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] mask_r;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] t_up;
    logic             up_carry;
    logic             cmd_apply;
    logic             cmd_count;
    logic             roll;
`ifdef JK_BANK_DOWN_COUNT_EN
    logic [WIDTH-1:0] t_down;
    logic             down_borrow;
`endif

    assign qb        = ~q;
    assign busy      = (state != IDLE);
    assign cmd_ready = (state == IDLE);

    // Ripple T-enables: a bit flips when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        up_carry = 1'b1;
        t_up     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            t_up[i]  = up_carry;
            up_carry = up_carry & q[i];
        end
    end

`ifdef JK_BANK_DOWN_COUNT_EN
    always_comb begin
        down_borrow = 1'b1;
        t_down      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            t_down[i]   = down_borrow;
            down_borrow = down_borrow & qb[i];
        end
    end
`endif

    always_comb begin
        cmd_apply = (cmd_op[2] == 1'b0);
`ifdef JK_BANK_DOWN_COUNT_EN
        cmd_count = (cmd_op == OP_UP) || (cmd_op == OP_DOWN);
`else
        cmd_count = (cmd_op == OP_UP);
`endif
    end

    always_comb begin
        j    = '0;
        k    = '0;
        roll = 1'b0;
        case (state)
            APPLY: begin
                case (op_r)
                    OP_SET:    j = mask_r;
                    OP_RESET:  k = mask_r;
                    OP_TOGGLE: begin
                        j = mask_r;
                        k = mask_r;
                    end
                    default: ;
                endcase
            end
            COUNT: begin
`ifdef JK_BANK_DOWN_COUNT_EN
                if (op_r == OP_DOWN) begin
                    j    = t_down;
                    k    = t_down;
                    roll = (q == '0);
                end else begin
                    j    = t_up;
                    k    = t_up;
                    roll = (&q);
                end
`else
                j    = t_up;
                k    = t_up;
                roll = (&q);
`endif
            end
            default: ;
        endcase
    end

    // Status pulses are set on the edge that enters DONE so they coincide with the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            q      <= '0;
            op_r   <= '0;
            mask_r <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            wrap   <= 1'b0;
            err    <= 1'b0;
        end else begin
            q    <= (j & ~q) | (~k & q);
            done <= 1'b0;
            wrap <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_r   <= cmd_op;
                        mask_r <= cmd_mask;
                        cnt    <= cmd_len;
                        if (cmd_apply) begin
                            state <= APPLY;
                        end else if (cmd_count && (cmd_len != '0)) begin
                            state <= COUNT;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= ~cmd_count;
                        end
                    end
                end
                APPLY: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                COUNT: begin
                    wrap <= roll;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed bench for jk_bank_ctrl: a command table with hand-computed results plus count-trace and reset corner cases.
module tb_jk_bank_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_mask;
    logic [CNT_W-1:0] cmd_len;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic             busy;
    logic             done;
    logic             wrap;
    logic             err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] mask;
        logic [CNT_W-1:0] len;
        logic [WIDTH-1:0] exp_q;
        int               exp_err;
        int               exp_wraps;
        int               exp_busy;
    } vec_t;

    vec_t vecs[14];

    jk_bank_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_len(cmd_len),
        .q(q), .qb(qb), .busy(busy), .done(done), .wrap(wrap), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Issues one command, then keeps cmd_valid high with a different command while busy to show it is not queued.
    task automatic applyStimulus(input int idx, input vec_t v);
        int busy_cnt, err_cnt, wrap_cnt, done_cnt, done_at, ready_bad, qb_bad, guard;
        busy_cnt = 0; err_cnt = 0; wrap_cnt = 0; done_cnt = 0; done_at = -1;
        ready_bad = 0; qb_bad = 0; guard = 0;
        checkOutput($sformatf("v%0d_ready", idx), 32'(cmd_ready), 32'd1);
        cmd_op    = v.op;
        cmd_mask  = v.mask;
        cmd_len   = v.len;
        cmd_valid = 1'b1;
        tick();
        cmd_op   = 3'b001;
        cmd_mask = '1;
        cmd_len  = 8'd5;
        while (busy && guard < 200) begin
            busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = busy_cnt;
            end
            if (err) err_cnt++;
            if (wrap) wrap_cnt++;
            if (cmd_ready) ready_bad++;
            if (qb !== ~q) qb_bad++;
            tick();
            guard++;
        end
        cmd_valid = 1'b0;
        checkOutput($sformatf("v%0d_idle", idx), 32'(busy), 32'd0);
        checkOutput($sformatf("v%0d_q", idx), 32'(q), 32'(v.exp_q));
        checkOutput($sformatf("v%0d_err", idx), 32'(err_cnt), 32'(v.exp_err));
        checkOutput($sformatf("v%0d_wraps", idx), 32'(wrap_cnt), 32'(v.exp_wraps));
        checkOutput($sformatf("v%0d_busy", idx), 32'(busy_cnt), 32'(v.exp_busy));
        checkOutput($sformatf("v%0d_done", idx), 32'(done_cnt), 32'd1);
        checkOutput($sformatf("v%0d_done_last", idx), 32'(done_at), 32'(v.exp_busy));
        checkOutput($sformatf("v%0d_ready_busy", idx), 32'(ready_bad), 32'd0);
        checkOutput($sformatf("v%0d_qb", idx), 32'(qb_bad), 32'd0);
    endtask

    initial begin
        int done_seen, busy_seen, q_moved;

        vecs[0]  = '{3'b001, 4'b1010, 8'd0,  4'b1010, 0, 0, 2};
        vecs[1]  = '{3'b011, 4'b0110, 8'd0,  4'b1100, 0, 0, 2};
        vecs[2]  = '{3'b010, 4'b1000, 8'd0,  4'b0100, 0, 0, 2};
        vecs[3]  = '{3'b000, 4'b1111, 8'd0,  4'b0100, 0, 0, 2};
        vecs[4]  = '{3'b001, 4'b1010, 8'd0,  4'b1110, 0, 0, 2};
        vecs[5]  = '{3'b100, 4'b0000, 8'd3,  4'b0001, 0, 1, 4};
        vecs[6]  = '{3'b100, 4'b1111, 8'd0,  4'b0001, 0, 0, 1};
        vecs[7]  = '{3'b111, 4'b1111, 8'd3,  4'b0001, 1, 0, 1};
`ifdef JK_BANK_DOWN_COUNT_EN
        vecs[8]  = '{3'b101, 4'b0000, 8'd2,  4'b1111, 0, 1, 3};
        vecs[9]  = '{3'b110, 4'b0101, 8'd5,  4'b1111, 1, 0, 1};
        vecs[10] = '{3'b100, 4'b0000, 8'd20, 4'b0011, 0, 2, 21};
        vecs[11] = '{3'b011, 4'b1111, 8'd0,  4'b1100, 0, 0, 2};
`else
        vecs[8]  = '{3'b101, 4'b0000, 8'd2,  4'b0001, 1, 0, 1};
        vecs[9]  = '{3'b110, 4'b0101, 8'd5,  4'b0001, 1, 0, 1};
        vecs[10] = '{3'b100, 4'b0000, 8'd20, 4'b0101, 0, 1, 21};
        vecs[11] = '{3'b011, 4'b1111, 8'd0,  4'b1010, 0, 0, 2};
`endif
        vecs[12] = '{3'b010, 4'b1111, 8'd0,  4'b0000, 0, 0, 2};
        vecs[13] = '{3'b001, 4'b1110, 8'd0,  4'b1110, 0, 0, 2};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_mask = '0; cmd_len = '0;
        tick();
        tick();
        checkOutput("rst_q", 32'(q), 32'h0);
        checkOutput("rst_qb", 32'(qb), 32'hF);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_pulses", 32'({done, wrap, err}), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) begin
            applyStimulus(i, vecs[i]);
        end

        $display("[TB] count-up trace from 1110");
        cmd_op = 3'b100; cmd_mask = '0; cmd_len = 8'd3; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        checkOutput("trace0_q", 32'(q), 32'hE);
        checkOutput("trace0_busy", 32'(busy), 32'd1);
        tick();
        checkOutput("trace1_q", 32'(q), 32'hF);
        checkOutput("trace1_wrap", 32'(wrap), 32'd0);
        tick();
        checkOutput("trace2_q", 32'(q), 32'h0);
        checkOutput("trace2_wrap", 32'(wrap), 32'd1);
        checkOutput("trace2_done", 32'(done), 32'd0);
        tick();
        checkOutput("trace3_q", 32'(q), 32'h1);
        checkOutput("trace3_done", 32'(done), 32'd1);
        checkOutput("trace3_wrap", 32'(wrap), 32'd0);
        tick();
        checkOutput("trace4_busy", 32'(busy), 32'd0);
        checkOutput("trace4_done", 32'(done), 32'd0);

        $display("[TB] reset during count-up len=10");
        cmd_op = 3'b100; cmd_len = 8'd10; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        checkOutput("midcnt_q", 32'(q), 32'h3);
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 3'b001; cmd_mask = '1; cmd_len = '0;
        tick();
        rst = 1'b0; cmd_valid = 1'b0;
        checkOutput("midrst_q", 32'(q), 32'h0);
        checkOutput("midrst_qb", 32'(qb), 32'hF);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_ready", 32'(cmd_ready), 32'd1);
        checkOutput("midrst_pulses", 32'({done, wrap, err}), 32'd0);
        done_seen = 0; busy_seen = 0; q_moved = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done) done_seen++;
            if (busy) busy_seen++;
            if (q != '0) q_moved++;
        end
        checkOutput("postrst_done", 32'(done_seen), 32'd0);
        checkOutput("postrst_busy", 32'(busy_seen), 32'd0);
        checkOutput("postrst_q", 32'(q_moved), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
